// File: rtl/ec11_decoder.sv
// EC11 rotary encoder front-end: synchronizes A/B/switch pins, decodes whole
// detents into a wrapping position and emits a debounced load strobe per press.
module ec11_decoder #(
  parameter int WIDTH    = 8,
  parameter int DEBOUNCE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             enc_sw,
  output logic [WIDTH-1:0] value,
  output logic             load,
  output logic             step,
  output logic             dir,
  output logic             err
);

  localparam logic [15:0] DB_LAST = 16'(DEBOUNCE - 1);

  logic [1:0]        a_sync;
  logic [1:0]        b_sync;
  logic [1:0]        sw_sync;
  logic [1:0]        ab;
  logic              sw;
  logic [1:0]        prev_ab;
  logic signed [3:0] acc;
  logic signed [3:0] acc_next;
  logic              cw;
  logic              ccw;
  logic              illegal;
  logic              commit;
  logic [15:0]       db_cnt;
  logic              btn_stable;
  logic              btn_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_sync  <= 2'b11;
      b_sync  <= 2'b11;
      sw_sync <= 2'b11;
    end else begin
      a_sync  <= {a_sync[0], enc_a};
      b_sync  <= {b_sync[0], enc_b};
      sw_sync <= {sw_sync[0], enc_sw};
    end
  end

  assign ab = {a_sync[1], b_sync[1]};
  assign sw = sw_sync[1];

  // CW order is 11 -> 01 -> 00 -> 10 -> 11; an illegal jump leaves acc as-is
  always_comb begin
    cw      = 1'b0;
    ccw     = 1'b0;
    illegal = ((ab ^ prev_ab) == 2'b11);
    case ({prev_ab, ab})
      4'b11_01, 4'b01_00, 4'b00_10, 4'b10_11: cw  = 1'b1;
      4'b01_11, 4'b00_01, 4'b10_00, 4'b11_10: ccw = 1'b1;
      default: ;
    endcase
    acc_next = acc;
    if (cw)
      acc_next = acc + 4'sd1;
    else if (ccw)
      acc_next = acc - 4'sd1;
    commit = (ab != prev_ab) && (ab == 2'b11);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_ab <= 2'b11;
      acc     <= 4'sd0;
      value   <= '0;
      step    <= 1'b0;
      dir     <= 1'b0;
      err     <= 1'b0;
    end else begin
      prev_ab <= ab;
      err     <= illegal;
      step    <= 1'b0;
      if (commit) begin
        acc <= 4'sd0;
        if (acc_next == 4'sd4) begin
          value <= value + {{(WIDTH-1){1'b0}}, 1'b1};
          step  <= 1'b1;
          dir   <= 1'b1;
        end else if (acc_next == -4'sd4) begin
          value <= value - {{(WIDTH-1){1'b0}}, 1'b1};
          step  <= 1'b1;
          dir   <= 1'b0;
        end
      end else begin
        acc <= acc_next;
      end
    end
  end

  // A level is accepted after DEBOUNCE consecutive differing samples
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_cnt     <= 16'd0;
      btn_stable <= 1'b1;
      btn_prev   <= 1'b1;
      load       <= 1'b0;
    end else begin
      btn_prev <= btn_stable;
      load     <= btn_prev & ~btn_stable;
      if (sw != btn_stable) begin
        if (db_cnt == DB_LAST) begin
          btn_stable <= sw;
          db_cnt     <= 16'd0;
        end else begin
          db_cnt <= db_cnt + 16'd1;
        end
      end else begin
        db_cnt <= 16'd0;
      end
    end
  end

endmodule

// File: tb/tb_ec11_decoder.sv
// Directed bench for ec11_decoder: table of held AB levels with expected
// position/pulse counts, plus hand sequences for debounce, reset and press+step.
module tb_ec11_decoder;

  localparam int DB = 16;

  logic       clk;
  logic       rst;
  logic       enc_a;
  logic       enc_b;
  logic       enc_sw;
  logic [7:0] value;
  logic       load;
  logic       step;
  logic       dir;
  logic       err;

  int checks = 0;
  int errors = 0;
  int step_cnt = 0;
  int err_cnt = 0;
  int load_cnt = 0;

  typedef struct {
    logic [1:0] ab;
    int         val;
    int         steps;
    logic       d;
    int         errs;
  } vec_t;

  vec_t vt[$];

  ec11_decoder #(.WIDTH(8), .DEBOUNCE(DB)) dut (
    .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .enc_sw(enc_sw),
    .value(value), .load(load), .step(step), .dir(dir), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (step) step_cnt++;
    if (err)  err_cnt++;
    if (load) load_cnt++;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] ab, input int val, input int st,
                     input logic d, input int e);
    vec_t v;
    v.ab = ab; v.val = val; v.steps = st; v.d = d; v.errs = e;
    vt.push_back(v);
  endtask

  // One full detent: three intermediate rows hold old value/dir, final row commits
  task automatic add_det(input logic is_cw, input int v0, input logic d0);
    int v1;
    v1 = is_cw ? (v0 + 1) % 256 : (v0 + 255) % 256;
    if (is_cw) begin
      add(2'b01, v0, 0, d0, 0); add(2'b00, v0, 0, d0, 0); add(2'b10, v0, 0, d0, 0);
    end else begin
      add(2'b10, v0, 0, d0, 0); add(2'b00, v0, 0, d0, 0); add(2'b01, v0, 0, d0, 0);
    end
    add(2'b11, v1, 1, is_cw, 0);
  endtask

  task automatic hold_ab(input logic [1:0] ab, input int n);
    {enc_a, enc_b} = ab;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int first_k;
    int step_k;
    int load_k;
    logic coincide;

    rst = 1'b0; enc_a = 1'b1; enc_b = 1'b1; enc_sw = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_value", value, 0);
    check("reset_pulses", {load, step, err}, 0);
    check("reset_dir", dir, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    add_det(1'b1, 0, 1'b0);
    add_det(1'b0, 1, 1'b1);
    add_det(1'b0, 0, 1'b0);
    add_det(1'b0, 255, 1'b0);
    add_det(1'b0, 254, 1'b0);
    // bounce: early return to 11 discards, then a clean detent
    add(2'b01, 253, 0, 1'b0, 0); add(2'b11, 253, 0, 1'b0, 0);
    add_det(1'b1, 253, 1'b0);
    // half detent
    add(2'b01, 254, 0, 1'b1, 0); add(2'b00, 254, 0, 1'b1, 0);
    add(2'b01, 254, 0, 1'b1, 0); add(2'b11, 254, 0, 1'b1, 0);
    // illegal 11->00, then acc=+2 at 11 is discarded
    add(2'b00, 254, 0, 1'b1, 1); add(2'b10, 254, 0, 1'b1, 0); add(2'b11, 254, 0, 1'b1, 0);
    add_det(1'b1, 254, 1'b1);
    add_det(1'b1, 255, 1'b1);
    add_det(1'b1, 0, 1'b1);

    foreach (vt[i]) begin
      step_cnt = 0; err_cnt = 0;
      hold_ab(vt[i].ab, 4);
      check($sformatf("row%0d_value", i), value, vt[i].val);
      check($sformatf("row%0d_steps", i), step_cnt, vt[i].steps);
      check($sformatf("row%0d_dir", i), dir, vt[i].d);
      check($sformatf("row%0d_err", i), err_cnt, vt[i].errs);
    end

    // switch glitch of DEBOUNCE-1 cycles
    load_cnt = 0;
    enc_sw = 1'b0;
    repeat (DB - 1) @(negedge clk);
    enc_sw = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_no_load", load_cnt, 0);

    // real press: load latency and single pulse
    load_cnt = 0;
    first_k = -1;
    enc_sw = 1'b0;
    for (int k = 1; k <= DB + 10; k++) begin
      @(negedge clk);
      if (load && first_k < 0) first_k = k;
    end
    check("press_latency", first_k, DB + 3);
    check("press_one_load", load_cnt, 1);
    enc_sw = 1'b1;
    repeat (DB + 10) @(negedge clk);
    check("release_no_load", load_cnt, 1);
    check("press_value_kept", value, 1);

    // reset mid-detent with pins at 00
    hold_ab(2'b01, 4);
    hold_ab(2'b00, 4);
    rst = 1'b0;
    #1;
    check("rst_async_value", value, 0);
    check("rst_async_dir", dir, 0);
    check("rst_async_pulses", {load, step, err}, 0);
    repeat (3) @(negedge clk);
    err_cnt = 0; step_cnt = 0;
    rst = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_err", err_cnt, 1);
    hold_ab(2'b10, 4);
    hold_ab(2'b11, 4);
    check("post_rst_value", value, 0);
    check("post_rst_steps", step_cnt, 0);

    // CW detent whose commit coincides with a debounced press
    step_k = -1; load_k = -1; coincide = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) @(negedge clk);
      if (step && step_k < 0) begin
        step_k = k;
        coincide = load && (value == 8'd1);
      end
      if (load && load_k < 0) load_k = k;
      if (k == 0)  enc_sw = 1'b0;
      if (k == 4)  {enc_a, enc_b} = 2'b01;
      if (k == 8)  {enc_a, enc_b} = 2'b00;
      if (k == 12) {enc_a, enc_b} = 2'b10;
      if (k == 16) {enc_a, enc_b} = 2'b11;
    end
    check("combo_step_cycle", step_k, 19);
    check("combo_load_cycle", load_k, 19);
    check("combo_same_cycle", coincide, 1);
    check("combo_value", value, 1);
    check("combo_dir", dir, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
